// File: rtl/mem_req_initiator_pkg.sv
// mem_req_initiator_pkg
//   Shared definitions for the memory request initiator: bus widths, the
//   watchdog width, the default watchdog limit and the FSM state encoding.
package mem_req_initiator_pkg;

  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 16;
  localparam int WD_W            = 8;   // watchdog width, covers TIMEOUT up to 255
  localparam int DEFAULT_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_req_initiator_if.sv
// mem_req_initiator_if
//   Bundles the pipeline request/response handshake and the memory-system bus.
//   Ports (by group):
//     req_*  : pipeline -> initiator request (valid/ready)
//     rsp_*  : initiator -> pipeline one-cycle response pulse
//     mem_*  : initiator <-> cached memory system (Addr/DataIn/Rd/Wr, DataOut/Done/Stall/CacheHit/err)
//   Modports: master = initiator view, slave = pipeline + memory system view.
//
//   Handshake: a request transfers on a rising clk edge where req_valid and
//   req_ready are both high; while req_valid is high and req_ready is low the
//   requester holds req_wr/req_addr/req_wdata stable. rsp_valid is a
//   one-cycle pulse with no back-pressure; rsp_rdata/rsp_err are valid only
//   with it.
interface mem_req_initiator_if;
  import mem_req_initiator_pkg::*;

  logic              req_valid;
  logic              req_wr;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              req_ready;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_done;
  logic              mem_stall;
  logic              mem_cache_hit;
  logic              mem_err;

  modport master (
    input  req_valid, req_wr, req_addr, req_wdata,
    input  mem_data_out, mem_done, mem_stall, mem_cache_hit, mem_err,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_addr, mem_data_in, mem_rd, mem_wr
  );

  modport slave (
    output req_valid, req_wr, req_addr, req_wdata,
    output mem_data_out, mem_done, mem_stall, mem_cache_hit, mem_err,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_addr, mem_data_in, mem_rd, mem_wr
  );

endinterface

// File: rtl/mem_req_initiator_sat_counter.sv
// mem_req_initiator_sat_counter
//   W-bit synchronous-reset incrementer that sticks at all-ones.
//   Ports: clk, rst (sync, active-high), en (increment request), count.
module mem_req_initiator_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_req_initiator.sv
// mem_req_initiator
//   Initiator side of the processor-to-memory handshake. Accepts one
//   load/store at a time from the pipeline, drives the memory-system bus
//   until Done (or a watchdog timeout), then returns a one-cycle response.
//   Ports:
//     clk, rst            : clock, synchronous active-high reset
//     bus (master)        : request/response handshake and memory bus
//     hit_count/miss_count: saturating counts of completed cache hits/misses
//     busy                : transaction outstanding on the memory bus
//     dbg_state           : current FSM state
//     dbg_stall           : memory system is stalling an issued request
module mem_req_initiator
  import mem_req_initiator_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_req_initiator_if.master  bus,
  output logic [CNT_W-1:0]     hit_count,
  output logic [CNT_W-1:0]     miss_count,
  output logic                 busy,
  output state_t               dbg_state,
  output logic                 dbg_stall
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              wr_q;
  logic [WD_W-1:0]   wd_q;
  logic              err_sticky_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rerr_q;

  logic accept;
  logic misaligned;
  logic done_seen;
  logic wd_expired;

  // ---------------- next state / outputs ----------------
  always_comb begin
    state_nxt  = state;
    accept     = (state == IDLE) && bus.req_valid;
    misaligned = bus.req_addr[0];
    done_seen  = (state == ISSUE) && bus.mem_done;
    // Done wins over the watchdog when both land in the same cycle.
    wd_expired = (state == ISSUE) && !bus.mem_done && (wd_q == WD_W'(TIMEOUT - 1));

    case (state)
      IDLE:    if (bus.req_valid) state_nxt = misaligned ? RESP : ISSUE;
      ISSUE:   if (done_seen || wd_expired) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    bus.req_ready   = (state == IDLE);
    bus.rsp_valid   = (state == RESP);
    bus.rsp_rdata   = rdata_q;
    bus.rsp_err     = rerr_q;
    bus.mem_addr    = addr_q;
    bus.mem_data_in = wdata_q;
    bus.mem_rd      = (state == ISSUE) && !wr_q;
    bus.mem_wr      = (state == ISSUE) && wr_q;
    busy            = (state == ISSUE);
    dbg_state       = state;
    dbg_stall       = (state == ISSUE) && bus.mem_stall;
  end

  // ---------------- state and request/response registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      wr_q         <= 1'b0;
      wd_q         <= '0;
      err_sticky_q <= 1'b0;
      rdata_q      <= '0;
      rerr_q       <= 1'b0;
    end else begin
      state <= state_nxt;

      if (accept) begin
        if (misaligned) begin
          // Rejected without touching the memory bus; bus registers keep old values.
          rdata_q <= '0;
          rerr_q  <= 1'b1;
        end else begin
          addr_q       <= bus.req_addr;
          wdata_q      <= bus.req_wdata;
          wr_q         <= bus.req_wr;
          wd_q         <= '0;
          err_sticky_q <= 1'b0;
        end
      end

      if (state == ISSUE) begin
        wd_q <= wd_q + 1'b1;
        // An error seen before Done is remembered and reported at completion.
        if (bus.mem_err) err_sticky_q <= 1'b1;
        if (bus.mem_done) begin
          rdata_q <= wr_q ? '0 : bus.mem_data_out;
          rerr_q  <= bus.mem_err | err_sticky_q;
        end else if (wd_expired) begin
          rdata_q <= '0;
          rerr_q  <= 1'b1;
        end
      end
    end
  end

  // ---------------- statistics ----------------
  mem_req_initiator_sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (done_seen && bus.mem_cache_hit),
    .count (hit_count)
  );

  mem_req_initiator_sat_counter #(.W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (done_seen && !bus.mem_cache_hit),
    .count (miss_count)
  );

endmodule

// File: tb/tb_mem_req_initiator.sv
module tb_mem_req_initiator;
  import mem_req_initiator_pkg::*;

  localparam int T     = 12;
  localparam int CW    = 3;
  localparam int SAT   = (1 << CW) - 1;
  localparam int EXP_W = 65;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_req_initiator_if bus_if ();
  logic [CW-1:0] hit_count, miss_count;
  logic          busy;
  state_t        dbg_state;
  logic          dbg_stall;

  mem_req_initiator #(.TIMEOUT(T), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .busy       (busy),
    .dbg_state  (dbg_state),
    .dbg_stall  (dbg_stall)
  );

  // ---------------- scoreboard state ----------------
  // entry: {cycle[31:0], miss[7:0], hit[7:0], err, rdata[15:0]}
  logic [EXP_W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int model_hit  = 0;
  int model_miss = 0;

  // expected memory-bus activity window and contents
  int          bus_lo = 1;
  int          bus_hi = 0;
  logic [15:0] bus_addr = '0;
  logic [15:0] bus_wdata = '0;
  logic        bus_wr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- response monitor ----------------
  logic [EXP_W-1:0] mon_e;
  always @(negedge clk) begin
    if (!rst && bus_if.rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata",  bus_if.rsp_rdata, mon_e[15:0]);
        chk("rsp_err",    bus_if.rsp_err,   mon_e[16]);
        chk("hit_count",  hit_count,        mon_e[24:17]);
        chk("miss_count", miss_count,       mon_e[32:25]);
        chk("rsp_cycle",  cyc,              mon_e[64:33]);
      end
    end
  end

  // ---------------- memory-bus checker ----------------
  logic exp_act;
  always @(negedge clk) begin
    if (!rst) begin
      exp_act = (cyc >= bus_lo) && (cyc <= bus_hi);
      chk("mem_active", bus_if.mem_rd | bus_if.mem_wr, exp_act);
      chk("busy",       busy, exp_act);
      chk("rd_wr_excl", bus_if.mem_rd & bus_if.mem_wr, 0);
      if (exp_act) begin
        chk("mem_rd",   bus_if.mem_rd,   !bus_wr);
        chk("mem_wr",   bus_if.mem_wr,   bus_wr);
        chk("mem_addr", bus_if.mem_addr, bus_addr);
        if (bus_wr) chk("mem_data_in", bus_if.mem_data_in, bus_wdata);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready();
    int guard = 0;
    @(negedge clk);
    while (!bus_if.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("req_ready_wait", bus_if.req_ready, 1);
  endtask

  // d: cycles of stall before Done (d >= T means Done never comes)
  // early_k: ISSUE cycle index of an err pulse before Done, -1 for none
  task automatic do_req(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        input int d, input logic hit, input logic err_done,
                        input int early_k, input logic [15:0] mem_rdata);
    int a, n;
    logic aligned;
    logic [15:0] rd;
    logic er;
    logic [31:0] w;
    wait_ready();
    if (!bus_if.req_ready) return;
    a = cyc + 1;
    aligned = !addr[0];
    // transaction-level reference model
    if (!aligned) begin
      n = 0; rd = '0; er = 1'b1;
    end else if (d <= T - 1) begin
      n  = d + 1;
      rd = wr ? 16'h0 : mem_rdata;
      er = err_done | (early_k >= 0 && early_k < d);
      if (hit) model_hit  = (model_hit  < SAT) ? model_hit + 1  : SAT;
      else     model_miss = (model_miss < SAT) ? model_miss + 1 : SAT;
    end else begin
      n = T; rd = '0; er = 1'b1;
    end
    w = a + n;
    bus_addr = addr; bus_wdata = wdata; bus_wr = wr;
    if (aligned) begin bus_lo = a; bus_hi = a + n - 1; end
    else         begin bus_lo = 1; bus_hi = 0; end
    exp_q.push_back({w, 8'(model_miss), 8'(model_hit), er, rd});

    bus_if.req_valid = 1'b1;
    bus_if.req_wr    = wr;
    bus_if.req_addr  = addr;
    bus_if.req_wdata = wdata;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    bus_if.req_addr  = 16'($urandom);
    bus_if.req_wdata = 16'($urandom);
    if (aligned) begin
      for (int k = 0; k < n; k++) begin
        bus_if.mem_done      = (k == d);
        bus_if.mem_stall     = (k != d);
        bus_if.mem_cache_hit = (k == d) ? hit : 1'($urandom_range(0, 1));
        bus_if.mem_data_out  = (k == d) ? mem_rdata : 16'($urandom);
        bus_if.mem_err       = (k == d) ? err_done : (k == early_k);
        @(negedge clk);
      end
      bus_if.mem_done  = 1'b0;
      bus_if.mem_stall = 1'b0;
      bus_if.mem_err   = 1'b0;
    end
  endtask

  task automatic stray_done();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_if.mem_done      = 1'b1;
      bus_if.mem_cache_hit = 1'($urandom_range(0, 1));
      bus_if.mem_err       = 1'b1;
    end
    @(negedge clk);
    bus_if.mem_done = 1'b0;
    bus_if.mem_err  = 1'b0;
    repeat (2) @(negedge clk);
    chk("stray_hit",  hit_count,  model_hit);
    chk("stray_miss", miss_count, model_miss);
  endtask

  task automatic reset_midop();
    int a;
    wait_ready();
    a = cyc + 1;
    bus_addr = 16'h0040; bus_wdata = 16'h0; bus_wr = 1'b0;
    bus_lo = a; bus_hi = a + 2;
    bus_if.req_valid = 1'b1;
    bus_if.req_wr    = 1'b0;
    bus_if.req_addr  = 16'h0040;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;                   // third ISSUE cycle
    model_hit = 0; model_miss = 0;
    @(negedge clk);
    bus_lo = 1; bus_hi = 0;
    exp_q.delete();
    chk("rst_mid_mem_rd",    bus_if.mem_rd,    0);
    chk("rst_mid_req_ready", bus_if.req_ready, 1);
    chk("rst_mid_rsp_valid", bus_if.rsp_valid, 0);
    chk("rst_mid_hit",       hit_count,        0);
    chk("rst_mid_miss",      miss_count,       0);
    chk("rst_mid_state",     dbg_state,        IDLE);
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    bus_if.req_valid = 1'b0; bus_if.req_wr = 1'b0;
    bus_if.req_addr = '0; bus_if.req_wdata = '0;
    bus_if.mem_data_out = '0; bus_if.mem_done = 1'b0; bus_if.mem_stall = 1'b0;
    bus_if.mem_cache_hit = 1'b0; bus_if.mem_err = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready",   bus_if.req_ready,   1);
    chk("rst_rsp_valid",   bus_if.rsp_valid,   0);
    chk("rst_rsp_rdata",   bus_if.rsp_rdata,   0);
    chk("rst_rsp_err",     bus_if.rsp_err,     0);
    chk("rst_mem_rd",      bus_if.mem_rd,      0);
    chk("rst_mem_wr",      bus_if.mem_wr,      0);
    chk("rst_mem_addr",    bus_if.mem_addr,    0);
    chk("rst_mem_data_in", bus_if.mem_data_in, 0);
    chk("rst_hit",         hit_count,          0);
    chk("rst_miss",        miss_count,         0);
    chk("rst_busy",        busy,               0);
    rst = 1'b0;

    // directed cases
    do_req(1'b0, 16'h0010, 16'h0000, 0,  1'b1, 1'b0, -1, 16'hBEEF);  // load hit
    do_req(1'b1, 16'h0200, 16'h1234, 10, 1'b0, 1'b0, -1, 16'h5555);  // store miss
    do_req(1'b0, 16'h0003, 16'h0000, 0,  1'b1, 1'b0, -1, 16'h7777);  // misaligned
    do_req(1'b0, 16'h0100, 16'h0000, 99, 1'b0, 1'b0, -1, 16'h0000);  // timeout
    do_req(1'b0, 16'h0020, 16'h0000, 5,  1'b1, 1'b0, 2,  16'hCAFE);  // sticky err
    do_req(1'b1, 16'h0300, 16'hA5A5, T - 1, 1'b1, 1'b1, -1, 16'h0);  // Done on last cycle
    stray_done();

    // randomized traffic
    for (int i = 0; i < 60; i++) begin
      logic [15:0] ad;
      int d, ek;
      ad = 16'($urandom);
      ad[0] = ($urandom_range(0, 5) == 0);
      d  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, T + 3)) : int'($urandom_range(0, 3));
      ek = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, d)) : -1;
      do_req(1'($urandom_range(0, 1)), ad, 16'($urandom), d,
             1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0), ek, 16'($urandom));
      if ($urandom_range(0, 9) == 0) stray_done();
    end

    reset_midop();
    stray_done();

    // saturation: back-to-back hits plus a few misses
    for (int i = 0; i < 9; i++)
      do_req(1'b0, 16'(i * 2), 16'h0, 0, 1'b1, 1'b0, -1, 16'($urandom));
    for (int i = 0; i < 2; i++)
      do_req(1'b1, 16'h0400, 16'h0F0F, 1, 1'b0, 1'b0, -1, 16'h0);
    repeat (4) @(negedge clk);
    chk("hit_saturated", hit_count, SAT);
    chk("miss_after_sat", miss_count, model_miss);

    repeat (5) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL global_timeout: got no end of stimulus expected finish within time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
